// File: rtl/cla_pkg.sv
// cla_pkg
//   Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   - GROUP_W     : width of one lookahead group (4 bits).
//   - alu_flags_t : status flags {ovf, zero, neg} for branch evaluation.
//   - cla_cfg_ok  : elaboration-time legality check of WIDTH/STAGES.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  // WIDTH must split into whole 4-bit groups, and the groups must divide
  // evenly across the pipeline stages.
  function automatic bit cla_cfg_ok(input int width, input int stages);
    return (width > 0) && (stages > 0) &&
           ((width % GROUP_W) == 0) &&
           (((width / GROUP_W) % stages) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// cla_group4
//   4-bit carry-lookahead adder group. All internal carries are formed in
//   two-level sum-of-products form from bit propagate/generate.
//   Ports:
//     a_i, b_i [3:0] : operand bits of this group
//     cin_i          : carry into the group
//     sum_o   [3:0]  : sum bits
//     p_o            : group propagate (carry-in passes straight through)
//     g_o            : group generate (group produces a carry by itself)
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               cin_i,
  output logic [GROUP_W-1:0] sum_o,
  output logic               p_o,
  output logic               g_o
);

  logic [GROUP_W-1:0] p_s;
  logic [GROUP_W-1:0] g_s;
  logic [GROUP_W-1:0] c_s;

  assign p_s = a_i ^ b_i;
  assign g_s = a_i & b_i;

  assign c_s[0] = cin_i;
  assign c_s[1] = g_s[0] | (p_s[0] & cin_i);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_i);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0]) |
                  (p_s[2] & p_s[1] & p_s[0] & cin_i);

  assign sum_o = p_s ^ c_s;

  // Group P/G are independent of cin_i so the stage lookahead unit has no
  // dependency back through the groups.
  assign p_o = &p_s;
  assign g_o = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1]) |
               (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor. WIDTH bits are split into
//   STAGES slices of SW = WIDTH/STAGES bits; each stage adds one slice with
//   SW/4 lookahead groups and a two-level lookahead carry unit, and passes
//   its carry-out to the next stage through a register. Operand bits of the
//   slices still to be added are skewed forward alongside the finished low
//   sum bits. Valid/ready handshake on both sides; one beat per cycle.
//   Optional feature macro: CLA_PIPE_FLAGS_EN builds the ovf/zero/neg flags;
//   without it those outputs are tied to 0.
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     in_valid, in_ready  : input handshake (in_ready = stage 0 can advance)
//     a, b, sub, c_in     : operands, 1 = subtract, carry/borrow-in
//     out_valid, out_ready: output handshake
//     sum, c_out          : result and carry out of the MSB
//     ovf, zero, neg      : signed overflow, sum == 0, sum MSB
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP_W;

  if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and WIDTH/4 divisible by STAGES");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM_IN = WIDTH - k * SW;   // operand bits arriving here
    localparam int DONE_W = (k + 1) * SW;     // sum bits finished after here

    logic [REM_IN-1:0] up_a_s;
    logic [REM_IN-1:0] up_b_s;
    logic              up_cin_s;
    logic              up_vld_s;
    logic              en_s;
    logic              dn_en_s;
    logic [SW-1:0]     ssum_s;
    logic [NG:0]       gc_s;
    logic [NG-1:0]     gp_s;
    logic [NG-1:0]     gg_s;
    logic [DONE_W-1:0] sum_lo_d;
    logic [DONE_W-1:0] sum_lo_q;
    logic              cy_q;
    logic              valid_q;

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    // Subtraction inverts B and the carry-in at the entry only.
    if (k == 0) begin : g_src
      assign up_a_s   = a;
      assign up_b_s   = b ^ {WIDTH{sub}};
      assign up_cin_s = c_in ^ sub;
      assign up_vld_s = in_valid;
      assign sum_lo_d = ssum_s;
    end else begin : g_src
      assign up_a_s   = g_stage[k-1].g_fwd.a_rem_q;
      assign up_b_s   = g_stage[k-1].g_fwd.b_rem_q;
      assign up_cin_s = g_stage[k-1].cy_q;
      assign up_vld_s = g_stage[k-1].valid_q;
      assign sum_lo_d = {ssum_s, g_stage[k-1].sum_lo_q};
    end

    // A stage may load when it is empty or the stage after it moves on.
    if (k == STAGES - 1) begin : g_dn
      assign dn_en_s = out_ready;
    end else begin : g_dn
      assign dn_en_s = g_stage[k+1].en_s;
    end
    assign en_s = !valid_q || dn_en_s;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group4 u_grp (
        .a_i   (up_a_s[j*GROUP_W +: GROUP_W]),
        .b_i   (up_b_s[j*GROUP_W +: GROUP_W]),
        .cin_i (gc_s[j]),
        .sum_o (ssum_s[j*GROUP_W +: GROUP_W]),
        .p_o   (gp_s[j]),
        .g_o   (gg_s[j])
      );
    end

    // Lookahead carry unit: each group carry is an independent OR of
    // generate terms gated by the propagates above them, so no carry ripples
    // from one group to the next.
    always_comb begin
      logic cy_s;
      logic term_s;
      gc_s = {(NG + 1){1'b0}};
      for (int j = 0; j <= NG; j++) begin
        cy_s = up_cin_s;
        for (int m = 0; m < j; m++) begin
          cy_s = cy_s & gp_s[m];
        end
        for (int i = 0; i < j; i++) begin
          term_s = gg_s[i];
          for (int m = i + 1; m < j; m++) begin
            term_s = term_s & gp_s[m];
          end
          cy_s = cy_s | term_s;
        end
        gc_s[j] = cy_s;
      end
    end

    // Stage valid bit, finished sum bits and slice carry-out.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q  <= 1'b0;
        cy_q     <= 1'b0;
        sum_lo_q <= {DONE_W{1'b0}};
      end else if (en_s) begin
        valid_q <= up_vld_s;
        if (up_vld_s) begin
          cy_q     <= gc_s[NG];
          sum_lo_q <= sum_lo_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int REM_OUT = REM_IN - SW;
      logic [REM_OUT-1:0] a_rem_q;
      logic [REM_OUT-1:0] b_rem_q;

      // Skew operand bits of the higher slices forward to later stages.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_rem_q <= {REM_OUT{1'b0}};
          b_rem_q <= {REM_OUT{1'b0}};
        end else if (en_s && up_vld_s) begin
          a_rem_q <= up_a_s[REM_IN-1:SW];
          b_rem_q <= up_b_s[REM_IN-1:SW];
        end
      end
    end
  end

  assign in_ready  = g_stage[0].en_s;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_lo_q;
  assign c_out     = g_stage[STAGES-1].cy_q;

`ifdef CLA_PIPE_FLAGS_EN
  alu_flags_t flags_d;
  alu_flags_t flags_q;

  // Flags from the last stage result; the carry into the MSB is recovered
  // as sum ^ a ^ effB at that bit.
  always_comb begin
    logic msb_cin_s;
    msb_cin_s = g_stage[STAGES-1].ssum_s[SW-1] ^
                g_stage[STAGES-1].up_a_s[SW-1] ^
                g_stage[STAGES-1].up_b_s[SW-1];
    flags_d.ovf  = msb_cin_s ^ g_stage[STAGES-1].gc_s[NG];
    flags_d.zero = (g_stage[STAGES-1].sum_lo_d == {WIDTH{1'b0}});
    flags_d.neg  = g_stage[STAGES-1].sum_lo_d[WIDTH-1];
  end

  // Flags load together with the last stage data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= alu_flags_t'(3'b000);
    end else if (g_stage[STAGES-1].en_s && g_stage[STAGES-1].up_vld_s) begin
      flags_q <= flags_d;
    end
  end

  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
  assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub
//   Scoreboard bench for cla_pipe_addsub: a 16-bit/2-stage instance for
//   directed, backpressure and reset cases, and a 32-bit/4-stage instance for
//   a random stream under random out_ready.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16;
  logic        cout16, ovf16, zero16, neg16;
  logic [15:0] a16, b16, sum16;

  logic        in_valid32, in_ready32, sub32, cin32, out_valid32, out_ready32;
  logic        cout32, ovf32, zero32, neg32;
  logic [31:0] a32, b32, sum32;

  cla_pipe_addsub #(.WIDTH(16), .STAGES(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .c_in(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .c_out(cout16), .ovf(ovf16), .zero(zero16), .neg(neg16)
  );

  cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .c_in(cin32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .c_out(cout32), .ovf(ovf32), .zero(zero32), .neg(neg32)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  res_t q16[$];
  res_t q32[$];
  int   n_total = 0;
  int   n_bad   = 0;
  bit   rand_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [31:0] s, input logic co, input logic ov,
                              input logic z, input logic n);
    res_t r;
    r.sum  = s;
    r.cout = co;
    r.ovf  = FLAGS_ON & ov;
    r.zero = FLAGS_ON & z;
    r.neg  = FLAGS_ON & n;
    return r;
  endfunction

  // Reference: plain wide addition; carry into the MSB from a (w-1)-bit add.
  function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic s, input logic ci);
    logic [63:0] mask, m1, eb, full, part;
    logic [31:0] sm;
    logic        eci;
    mask = (64'd1 << w) - 64'd1;
    m1   = mask >> 1;
    eci  = ci ^ s;
    eb   = ({32'd0, bv} ^ (s ? mask : 64'd0)) & mask;
    full = ({32'd0, av} & mask) + eb + {63'd0, eci};
    part = ({32'd0, av} & m1) + (eb & m1) + {63'd0, eci};
    sm   = full[31:0] & mask[31:0];
    return mk(sm, full[w], part[w-1] ^ full[w], sm == 32'd0, sm[w-1]);
  endfunction

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic s,
                        input logic ci, input res_t e);
    int n = 0;
    a16 = av; b16 = bv; sub16 = s; cin16 = ci; in_valid16 = 1'b1;
    @(negedge clk);
    while (!in_ready16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready16) check("acc16_timeout", 64'(in_ready16), 64'd1);
    else q16.push_back(e);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic ci, input res_t e);
    int n = 0;
    a32 = av; b32 = bv; sub32 = s; cin32 = ci; in_valid32 = 1'b1;
    @(negedge clk);
    while (!in_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready32) check("acc32_timeout", 64'(in_ready32), 64'd1);
    else q32.push_back(e);
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
  endtask

  task automatic drain16();
    int n = 0;
    out_ready16 = 1'b1;
    while (q16.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q16.size() != 0) check("drain16", 64'(q16.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain32();
    int n = 0;
    out_ready32 = 1'b1;
    while (q32.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q32.size() != 0) check("drain32", 64'(q32.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitors: a beat with valid&&ready at the negedge retires at the
  // next posedge; a stalled beat must be unchanged one cycle later.
  logic        stall16 = 1'b0;
  logic [19:0] held16  = 20'd0;
  always @(negedge clk) begin
    res_t e;
    if (rst_n && stall16) begin
      check("hold16_vld", 64'(out_valid16), 64'd1);
      check("hold16_res", 64'({sum16, cout16, ovf16, zero16, neg16}), 64'(held16));
    end
    if (rst_n && out_valid16 && out_ready16) begin
      if (q16.size() == 0) begin
        check("extra16", 64'(out_valid16), 64'd0);
      end else begin
        e = q16.pop_front();
        check("sum16", 64'(sum16), 64'(e.sum[15:0]));
        check("cout16", 64'(cout16), 64'(e.cout));
        check("flags16", 64'({ovf16, zero16, neg16}), 64'({e.ovf, e.zero, e.neg}));
      end
    end
    stall16 = rst_n && out_valid16 && !out_ready16;
    held16  = {sum16, cout16, ovf16, zero16, neg16};
  end

  logic        stall32 = 1'b0;
  logic [35:0] held32  = 36'd0;
  always @(negedge clk) begin
    res_t e;
    if (rst_n && stall32) begin
      check("hold32_vld", 64'(out_valid32), 64'd1);
      check("hold32_res", 64'({sum32, cout32, ovf32, zero32, neg32}), 64'(held32));
    end
    if (rst_n && out_ready32) check("thru32_rdy", 64'(in_ready32), 64'd1);
    if (rst_n && out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        check("extra32", 64'(out_valid32), 64'd0);
      end else begin
        e = q32.pop_front();
        check("sum32", 64'(sum32), 64'(e.sum));
        check("cout32", 64'(cout32), 64'(e.cout));
        check("flags32", 64'({ovf32, zero32, neg32}), 64'({e.ovf, e.zero, e.neg}));
      end
    end
    stall32 = rst_n && out_valid32 && !out_ready32;
    held32  = {sum32, cout32, ovf32, zero32, neg32};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] av16, bv16;
    logic [31:0] av, bv;
    logic        s, c;

    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = 16'd0; b16 = 16'd0; sub16 = 1'b0; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0; sub32 = 1'b0; cin32 = 1'b0; out_ready32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld16", 64'(out_valid16), 64'd0);
    check("rst_res16", 64'({sum16, cout16, ovf16, zero16, neg16}), 64'd0);
    check("rst_vld32", 64'(out_valid32), 64'd0);
    check("rst_res32", 64'({sum32, cout32, ovf32, zero32, neg32}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy16_after_rst", 64'(in_ready16), 64'd1);

    // Directed 16-bit cases with hand-computed results
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    check("lat16_early", 64'(out_valid16), 64'd0);
    @(posedge clk);
    #1;
    check("lat16_due", 64'(out_valid16), 64'd1);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(32'h0000_8000, 1'b0, 1'b1, 1'b0, 1'b1));
    send16(16'h0005, 16'h0007, 1'b1, 1'b0, mk(32'h0000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, mk(32'h0000_FFFD, 1'b0, 1'b0, 1'b0, 1'b1));
    send16(16'h1234, 16'h1234, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    drain16();

    // Four back-to-back beats with the consumer stalled for three cycles
    out_ready16 = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          av16 = 16'($urandom); bv16 = 16'($urandom); s = 1'($urandom); c = 1'($urandom);
          send16(av16, bv16, s, c, model(16, {16'd0, av16}, {16'd0, bv16}, s, c));
        end
      end
      begin
        @(posedge clk); #1;
        check("bp_rdy_one", 64'(in_ready16), 64'd1);
        @(posedge clk); #1;
        check("bp_rdy_full", 64'(in_ready16), 64'd0);
        @(posedge clk); #1;
        check("bp_rdy_full2", 64'(in_ready16), 64'd0);
        out_ready16 = 1'b1;
      end
    join
    drain16();

    // Reset with two beats in flight: both must vanish
    out_ready16 = 1'b0;
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, mk(32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b0));
    send16(16'h4444, 16'h1111, 1'b1, 1'b0, mk(32'h0000_3333, 1'b1, 1'b0, 1'b0, 1'b0));
    check("pre_rst_vld", 64'(out_valid16), 64'd1);
    rst_n = 1'b0;
    q16.delete();
    @(posedge clk);
    #1;
    check("mid_rst_vld", 64'(out_valid16), 64'd0);
    rst_n = 1'b1;
    out_ready16 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_vld", 64'(out_valid16), 64'd0);

    // Random 32-bit stream under random backpressure
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          av = $urandom; bv = $urandom; s = 1'($urandom); c = 1'($urandom);
          if ((i % 8) == 0) bv = ~av;
          if ((i % 16) == 1) begin bv = av; s = 1'b1; end
          if ((i % 16) == 2) begin av = 32'h7FFF_FFFF; bv = 32'd1; s = 1'b0; end
          send32(av, bv, s, c, model(32, av, bv, s, c));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready32 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain32();

    check("q16_empty", 64'(q16.size()), 64'd0);
    check("q32_empty", 64'(q32.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
